vga_word_scheduler: RTL and testbench
=====================================

# vga_word_scheduler

Controller that owns the word list shown by the VGA display path. Accepts edit commands (append pattern code, backspace, clear, commit) from the gesture classifier over a valid/ready handshake into an edit buffer. At the next frame boundary it copies that buffer into a display shadow buffer, so the VGA colour logic never sees a partially edited list mid-frame. It also raises the display start enable once the first list is committed.

## Interface
- MAX_WORDS, 32: entries in the word list.
- CODE_W, 8: pattern code width.
- CNT_W, $clog2(MAX_WORDS+1) = 6: word count width.
- i_clk  in  1  pixel clock (25 MHz).
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_cmd_op  in  2  operation: 0 = append, 1 = backspace, 2 = clear, 3 = commit.
- i_cmd_code  in  CODE_W  pattern code for append; ignored otherwise.
- i_frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank.
- o_word_cnt  out  CNT_W  committed word count.
- o_pattern_num  out  MAX_WORDS*CODE_W  committed codes; entry i at [i*CODE_W +: CODE_W].
- o_display_start  out  1  display enable; sticky high after first commit.
- o_overflow  out  1  one-cycle pulse: append rejected because the list is full.

## Operation
- **State machine:** S_IDLE, S_EDIT, S_COPY.
- **Reset values:**
  - State: S_IDLE.
  - Edit buffer entries: 0. Edit count: 0. Dirty: 0. Copy index: 0.
  - Display buffer: 0. o_word_cnt: 0.
  - o_display_start: 0. o_overflow: 0. o_cmd_ready: 1.
- **Ready:** o_cmd_ready = (state != S_COPY), combinational from state.
- **Accepted commands** (valid & ready) update the edit buffer in the same cycle:
  - Append: if edit count < MAX_WORDS, write edit[cnt] = code, cnt+1, dirty = 1. Otherwise no change; o_overflow pulses next cycle.
  - Backspace: if cnt > 0, cnt-1, clear edit[cnt-1] to 0, dirty = 1. If cnt = 0, no-op and dirty unchanged.
  - Clear: all edit entries 0, cnt 0, dirty = 1.
  - Commit: dirty = 1 only.
- **S_IDLE → S_EDIT** on any accepted command. i_frame_start is ignored in S_IDLE.
- **S_EDIT → S_COPY** when i_frame_start & dirty_next.
  - dirty_next includes a command accepted in the same cycle.
  - That command's edit takes effect first; the copy sees the updated buffer.
  - i_frame_start with dirty_next = 0 is ignored.
- **S_COPY:**
  - Each cycle: disp[idx] = edit[idx], idx+1. No command is accepted.
  - i_frame_start is ignored.
  - On idx = MAX_WORDS-1: o_word_cnt = edit count, dirty = 0, o_display_start = 1, idx = 0, go to S_EDIT.
- **Arithmetic:** counts are unsigned CNT_W; no wrap (bounds checked before inc/dec). Copy index is $clog2(MAX_WORDS) bits.

## Timing
- **Command latency:** edit-buffer update is visible 1 cycle after acceptance. Nothing reaches the outputs until a commit copy.
- **Copy duration:** exactly MAX_WORDS cycles (32) in S_COPY, starting the cycle after the qualifying i_frame_start.
  - The copy fits inside vertical blank (45 lines × 800 cycles).
- **Entry update order:**
  - o_pattern_num entry k changes k+1 cycles after the frame_start cycle.
  - o_word_cnt and o_display_start change on the same edge as the last entry.
- **Back-pressure:** o_cmd_ready drops the cycle after the qualifying frame_start and returns the cycle after the last copy. A pending valid must be held.
- **Reset mid-copy:** returns to the reset values on the next edge. The partial display buffer is discarded (cleared).

## Structure
- **Package vga_ctrl_pkg:**
  - State enum (S_IDLE, S_EDIT, S_COPY).
  - Op localparams (OP_APPEND, OP_BKSP, OP_CLEAR, OP_COMMIT).
  - Default MAX_WORDS / CODE_W.
- **Sub-modules:** none; the block is a single flat module.
- **Integration:**
  - o_word_cnt and o_pattern_num feed the display's word count / pattern inputs.
  - o_display_start drives the display's i_start.

## Test plan
- **Reset then frame pulses:** reset, then pulse i_frame_start with no commands → state stays S_IDLE, o_display_start = 0, o_word_cnt = 0.
- **Basic commit:** append 2, append 3, then frame_start → o_cmd_ready low for 32 cycles. Then o_pattern_num[0] = 2, [1] = 3, o_word_cnt = 2, o_display_start = 1.
- **Overflow:** append 33 codes (0..32) → 33rd gives an o_overflow pulse. After commit, o_word_cnt = 32 and entry 31 = 31.
- **Backspace and clear:**
  - Append 5, append 6, backspace, commit op, frame_start → o_word_cnt = 1, entry1 = 0.
  - Backspace at cnt 0 → dirty stays 0; the next frame_start triggers no copy.
- **Simultaneous command and frame pulse:** accepted append 9 in the same cycle as i_frame_start in S_EDIT → copy starts next cycle and includes 9.
- **Stall and mid-copy reset:**
  - A command held valid during S_COPY is accepted the cycle after copy ends.
  - i_rst asserted mid-copy → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA word-list controller.
// Holds the scheduler FSM states, command opcodes and default sizes.
package vga_ctrl_pkg;

  localparam int MAX_WORDS_DEF = 32;
  localparam int CODE_W_DEF    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT,
    S_COPY
  } sched_state_t;

  localparam logic [1:0] OP_APPEND = 2'd0;
  localparam logic [1:0] OP_BKSP   = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_COMMIT = 2'd3;

endpackage

// File: rtl/vga_word_scheduler.sv
// Word-list edit buffer with a frame-synchronous copy into a display shadow.
// The display side only ever sees a complete, committed list.
module vga_word_scheduler
  import vga_ctrl_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CODE_W    = CODE_W_DEF,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1),
  parameter int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [1:0]                  i_cmd_op,
  input  logic [CODE_W-1:0]           i_cmd_code,
  input  logic                        i_frame_start,
  output logic [CNT_W-1:0]            o_word_cnt,
  output logic [MAX_WORDS*CODE_W-1:0] o_pattern_num,
  output logic                        o_display_start,
  output logic                        o_overflow
);

  sched_state_t state_q, state_d;

  logic [CODE_W-1:0] edit_q [MAX_WORDS];
  logic [CODE_W-1:0] edit_d [MAX_WORDS];
  logic [CODE_W-1:0] disp_q [MAX_WORDS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wcnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             dirty_q, dirty_d;
  logic             ovf_q, ovf_d;
  logic             dstart_q;
  logic             accept;
  logic             copy_last;

  assign o_cmd_ready = (state_q != S_COPY);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign copy_last   = (idx_q == IDX_W'(MAX_WORDS - 1));

  // Edit-buffer next value; dirty_d already reflects this cycle's command
  always_comb begin
    edit_d  = edit_q;
    cnt_d   = cnt_q;
    dirty_d = dirty_q;
    ovf_d   = 1'b0;
    if (accept) begin
      unique case (i_cmd_op)
        OP_APPEND: begin
          if (cnt_q < CNT_W'(MAX_WORDS)) begin
            for (int i = 0; i < MAX_WORDS; i++)
              if (cnt_q == CNT_W'(i))
                edit_d[i] = i_cmd_code;
            cnt_d   = cnt_q + CNT_W'(1);
            dirty_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_BKSP: begin
          if (cnt_q != '0) begin
            for (int i = 0; i < MAX_WORDS; i++)
              if (cnt_q == CNT_W'(i + 1))
                edit_d[i] = '0;
            cnt_d   = cnt_q - CNT_W'(1);
            dirty_d = 1'b1;
          end
        end
        OP_CLEAR: begin
          for (int i = 0; i < MAX_WORDS; i++)
            edit_d[i] = '0;
          cnt_d   = '0;
          dirty_d = 1'b1;
        end
        default: dirty_d = 1'b1;
      endcase
    end
    if (state_q == S_COPY && copy_last)
      dirty_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_EDIT;
      S_EDIT: if (i_frame_start && dirty_d) state_d = S_COPY;
      S_COPY: if (copy_last) state_d = S_EDIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        edit_q[i] <= '0;
        disp_q[i] <= '0;
      end
      cnt_q    <= '0;
      dirty_q  <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      dstart_q <= 1'b0;
    end else begin
      edit_q  <= edit_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      ovf_q   <= ovf_d;
      if (state_q == S_COPY) begin
        disp_q[idx_q] <= edit_q[idx_q];
        if (copy_last) begin
          idx_q    <= '0;
          wcnt_q   <= cnt_q;
          dstart_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_pattern_num = '0;
    for (int i = 0; i < MAX_WORDS; i++)
      o_pattern_num[i*CODE_W +: CODE_W] = disp_q[i];
  end

  assign o_word_cnt      = wcnt_q;
  assign o_display_start = dstart_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_vga_word_scheduler.sv
// Directed and random stimulus for vga_word_scheduler against a
// list-level model of the edit/commit/copy behaviour.
module tb_vga_word_scheduler;

  localparam int MW = 32;
  localparam int CW = 8;
  localparam int NW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op = 2'd0;
  logic [CW-1:0] i_cmd_code = '0;
  logic          i_frame_start = 1'b0;
  logic [NW-1:0] o_word_cnt;
  logic [MW*CW-1:0] o_pattern_num;
  logic          o_display_start;
  logic          o_overflow;

  vga_word_scheduler dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_op        (i_cmd_op),
    .i_cmd_code      (i_cmd_code),
    .i_frame_start   (i_frame_start),
    .o_word_cnt      (o_word_cnt),
    .o_pattern_num   (o_pattern_num),
    .o_display_start (o_display_start),
    .o_overflow      (o_overflow)
  );

  always #20 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: list as a queue, committed snapshot, copy progress counter
  logic [CW-1:0] m_list [$];
  logic [CW-1:0] m_disp [MW];
  logic [CW-1:0] m_snap [MW];
  int            m_snap_cnt;
  int            m_copy_left;
  bit            m_started;
  bit            m_dirty;
  int            m_wcnt;
  bit            m_dstart;
  bit            m_ovf;

  task automatic model_reset();
    m_list.delete();
    for (int i = 0; i < MW; i++) begin
      m_disp[i] = '0;
      m_snap[i] = '0;
    end
    m_snap_cnt  = 0;
    m_copy_left = 0;
    m_started   = 0;
    m_dirty     = 0;
    m_wcnt      = 0;
    m_dstart    = 0;
    m_ovf       = 0;
  endtask

  task automatic model_cycle(input bit v, input logic [1:0] op,
                             input logic [CW-1:0] code, input bit fs);
    bit was_started;
    int k;
    m_ovf = 0;
    if (m_copy_left > 0) begin
      k = MW - m_copy_left;
      m_disp[k] = m_snap[k];
      m_copy_left--;
      if (m_copy_left == 0) begin
        m_wcnt   = m_snap_cnt;
        m_dstart = 1;
        m_dirty  = 0;
      end
    end else begin
      was_started = m_started;
      if (v) begin
        case (op)
          2'd0: if (m_list.size() < MW) begin
                  m_list.push_back(code);
                  m_dirty = 1;
                end else m_ovf = 1;
          2'd1: if (m_list.size() > 0) begin
                  void'(m_list.pop_back());
                  m_dirty = 1;
                end
          2'd2: begin
                  m_list.delete();
                  m_dirty = 1;
                end
          default: m_dirty = 1;
        endcase
        m_started = 1;
      end
      if (was_started && fs && m_dirty) begin
        for (int i = 0; i < MW; i++)
          m_snap[i] = (i < m_list.size()) ? m_list[i] : '0;
        m_snap_cnt  = m_list.size();
        m_copy_left = MW;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [MW*CW-1:0] exp_pat;
    for (int i = 0; i < MW; i++)
      exp_pat[i*CW +: CW] = m_disp[i];
    n_assert++;
    assert (o_cmd_ready === (m_copy_left == 0)) else begin
      n_fail++;
      $error("FAIL %s ready: got %0b exp %0b", tag, o_cmd_ready, m_copy_left == 0);
    end
    n_assert++;
    assert (o_overflow === m_ovf) else begin
      n_fail++;
      $error("FAIL %s overflow: got %0b exp %0b", tag, o_overflow, m_ovf);
    end
    n_assert++;
    assert (o_word_cnt === NW'(m_wcnt)) else begin
      n_fail++;
      $error("FAIL %s word_cnt: got %0d exp %0d", tag, o_word_cnt, m_wcnt);
    end
    n_assert++;
    assert (o_display_start === m_dstart) else begin
      n_fail++;
      $error("FAIL %s display_start: got %0b exp %0b", tag, o_display_start, m_dstart);
    end
    n_assert++;
    assert (o_pattern_num === exp_pat) else begin
      n_fail++;
      $error("FAIL %s pattern: got %h exp %h", tag, o_pattern_num, exp_pat);
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [1:0] op,
                      input logic [CW-1:0] code, input bit fs);
    i_cmd_valid   = v;
    i_cmd_op      = op;
    i_cmd_code    = code;
    i_frame_start = fs;
    model_cycle(v, op, code, fs);
    @(posedge i_clk);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_frame_start = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 2'd0, '0, 0);
  endtask

  initial begin
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset("reset");
    step("idle_fs", 0, 2'd0, '0, 1);
    step("idle_fs", 0, 2'd0, '0, 0);
    step("idle_fs", 0, 2'd0, '0, 1);

    step("basic", 1, 2'd0, 8'd2, 0);
    step("basic", 1, 2'd0, 8'd3, 0);
    step("basic_fs", 0, 2'd0, '0, 1);
    idle("basic_copy", 34);

    step("ovf", 1, 2'd2, '0, 0);
    for (int i = 0; i <= 32; i++) step("ovf", 1, 2'd0, CW'(i), 0);
    step("ovf", 1, 2'd3, '0, 0);
    step("ovf_fs", 0, 2'd0, '0, 1);
    idle("ovf_copy", 34);

    step("bksp", 1, 2'd2, '0, 0);
    step("bksp", 1, 2'd0, 8'd5, 0);
    step("bksp", 1, 2'd0, 8'd6, 0);
    step("bksp", 1, 2'd1, '0, 0);
    step("bksp", 1, 2'd3, '0, 0);
    step("bksp_fs", 0, 2'd0, '0, 1);
    idle("bksp_copy", 34);

    step("empty", 1, 2'd2, '0, 0);
    step("empty_fs", 0, 2'd0, '0, 1);
    idle("empty_copy", 34);
    step("bksp0", 1, 2'd1, '0, 0);
    step("bksp0_fs", 0, 2'd0, '0, 1);
    idle("bksp0_nocopy", 3);

    step("simul", 1, 2'd0, 8'd9, 1);
    for (int i = 0; i < 33; i++) step("stall", 1, 2'd0, 8'd77, 0);
    step("stall", 0, 2'd0, '0, 0);

    step("mid", 1, 2'd0, 8'd44, 0);
    step("mid_fs", 0, 2'd0, '0, 1);
    idle("mid_copy", 10);
    do_reset("mid_reset");
    idle("post_reset", 2);

    for (int i = 0; i < 4000; i++) begin
      logic [1:0] op;
      int r;
      r  = $urandom_range(0, 99);
      op = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
      step("rand", $urandom_range(0, 1) == 1, op, CW'($urandom),
           $urandom_range(0, 29) == 0);
    end
    idle("drain", 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
